mem_port_arbiter: RTL

Two-requester arbiter that shares one single-ported word memory (instruction/data memory top interface) between the core's instruction-fetch port and its load/store port. Sits between the core and the memory top. It registers the winning request onto the memory port, holds it until the memory returns `valid`, and routes the response back to its owner. A watchdog aborts any transaction the memory never completes.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/arb_watchdog.sv | 31 +++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_e;

  localparam logic MEM_WRITE = 1'b1;
  localparam logic MEM_READ  = 1'b0;

endpackage

// File: rtl/arb_watchdog.sv
// Transaction watchdog: counts cycles spent waiting on the memory and flags
// when the wait has reached TIMEOUT-1, so the owner can be aborted that cycle.
module arb_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Wait counter; restarts on every grant and saturates at its terminal value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported word memory between the
// instruction-fetch port and the load/store port, with a timeout abort.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic                i_we_re,
  input  logic [DATA_W/8-1:0] i_mask,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic                i_valid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_we_re,
  input  logic [DATA_W/8-1:0] d_mask,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic                d_load,
  output logic                d_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                m_request,
  output logic                m_we_re,
  output logic                m_load,
  output logic [DATA_W/8-1:0] m_mask,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_valid,
  input  logic [DATA_W-1:0]   m_rdata
);

  arb_state_e state, state_n;
  arb_owner_e last_grant;
  logic       grant_i, grant_d;
  logic       done;
  logic       expired;

  // The watchdog only runs while a transaction is outstanding and unanswered.
  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant_i || grant_d),
    .enable ((state != IDLE) && !m_valid),
    .expired(expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Arbitration and completion: ties go to whoever was not granted last.
  always_comb begin
    state_n = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || (last_grant == OWN_I))) begin
          grant_d = 1'b1;
          state_n = BUSY_D;
        end else if (i_req) begin
          grant_i = 1'b1;
          state_n = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_valid || expired) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Memory-side request registers, loaded from the winner and held while busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_request  <= 1'b0;
      m_we_re    <= MEM_READ;
      m_load     <= 1'b0;
      m_mask     <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      last_grant <= OWN_I;
    end else if (grant_i) begin
      m_request  <= 1'b1;
      m_we_re    <= i_we_re;
      m_load     <= 1'b0;
      m_mask     <= i_mask;
      m_addr     <= i_addr;
      m_wdata    <= i_wdata;
      last_grant <= OWN_I;
    end else if (grant_d) begin
      m_request  <= 1'b1;
      m_we_re    <= d_we_re;
      m_load     <= d_load;
      m_mask     <= d_mask;
      m_addr     <= d_addr;
      m_wdata    <= d_wdata;
      last_grant <= OWN_D;
    end else if (done) begin
      m_request  <= 1'b0;
    end
  end

  // Route completion or abort to the owner only; suppressed while in reset.
  always_comb begin
    i_valid = rst && (state == BUSY_I) && m_valid;
    d_valid = rst && (state == BUSY_D) && m_valid;
    i_err   = rst && (state == BUSY_I) && !m_valid && expired;
    d_err   = rst && (state == BUSY_D) && !m_valid && expired;
    i_rdata = i_valid ? m_rdata : '0;
    d_rdata = d_valid ? m_rdata : '0;
  end

endmodule
